// File: rtl/b_to_g_counter.sv
// Up/down binary counter with a registered Gray mirror, plus an independent binary-to-Gray converter.
// Latency: all outputs registered (1 cycle); no backpressure, every input is consumed on each edge.
module b_to_g_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             wrap,
    input  logic             cv_valid_in,
    input  logic [WIDTH-1:0] cv_bin_in,
    output logic             cv_valid_out,
    output logic [WIDTH-1:0] cv_gray_out
);

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             cv_valid_q, cv_valid_d;
    logic [WIDTH-1:0] cv_gray_q, cv_gray_d;

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (dir) begin
                bin_d  = bin_q + WIDTH'(1);
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - WIDTH'(1);
                wrap_d = ~|bin_q;
            end
        end
        // Encode from the next-state value so gray lands on the same edge as bin.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_comb begin
        cv_valid_d = cv_valid_in;
        cv_gray_d  = cv_gray_q;
        if (cv_valid_in) begin
            cv_gray_d = cv_bin_in ^ (cv_bin_in >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q      <= '0;
            gray_q     <= '0;
            wrap_q     <= 1'b0;
            cv_valid_q <= 1'b0;
            cv_gray_q  <= '0;
        end else begin
            bin_q      <= bin_d;
            gray_q     <= gray_d;
            wrap_q     <= wrap_d;
            cv_valid_q <= cv_valid_d;
            cv_gray_q  <= cv_gray_d;
        end
    end

    assign bin          = bin_q;
    assign gray         = gray_q;
    assign wrap         = wrap_q;
    assign cv_valid_out = cv_valid_q;
    assign cv_gray_out  = cv_gray_q;

endmodule

// File: tb/tb_b_to_g_counter.sv
// Directed and randomized bench for b_to_g_counter (WIDTH=8) against an arithmetic reference model.
module tb_b_to_g_counter;

    localparam int W = 8;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, dir = 1'b0, load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] bin, gray;
    logic         wrap;
    logic         cv_valid_in = 1'b0;
    logic [W-1:0] cv_bin_in = '0;
    logic         cv_valid_out;
    logic [W-1:0] cv_gray_out;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_bin = 0;
    int m_wrap = 0;
    int m_cv_valid = 0;
    int m_cv_gray = 0;

    b_to_g_counter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .dir(dir), .load(load), .load_bin(load_bin),
        .bin(bin), .gray(gray), .wrap(wrap),
        .cv_valid_in(cv_valid_in), .cv_bin_in(cv_bin_in),
        .cv_valid_out(cv_valid_out), .cv_gray_out(cv_gray_out)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(int x);
        return (x ^ (x >> 1)) % MOD;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".bin"},      32'(bin),          32'(m_bin));
        check({tag, ".gray"},     32'(gray),         32'(to_gray(m_bin)));
        check({tag, ".wrap"},     32'(wrap),         32'(m_wrap));
        check({tag, ".cv_valid"}, 32'(cv_valid_out), 32'(m_cv_valid));
        check({tag, ".cv_gray"},  32'(cv_gray_out),  32'(m_cv_gray));
    endtask

    // Drive one cycle of inputs, advance one edge, update the model, compare everything.
    task automatic step(string tag, logic e, logic d, logic l, logic [W-1:0] lb,
                        logic cvv, logic [W-1:0] cvb);
        logic [W-1:0] prev_gray;
        int nb;
        en = e; dir = d; load = l; load_bin = lb;
        cv_valid_in = cvv; cv_bin_in = cvb;
        prev_gray = gray;
        @(posedge clk);
        #1;
        if (l) begin
            m_bin = int'(lb); m_wrap = 0;
        end else if (e) begin
            nb = d ? m_bin + 1 : m_bin - 1;
            m_wrap = (nb < 0 || nb >= MOD) ? 1 : 0;
            m_bin = (nb + MOD) % MOD;
        end else begin
            m_wrap = 0;
        end
        m_cv_valid = int'(cvv);
        if (cvv) m_cv_gray = to_gray(int'(cvb));
        check_all(tag);
        if (e && !l) check({tag, ".onebit"}, 32'($countones(gray ^ prev_gray)), 32'd1);
    endtask

    task automatic model_reset();
        m_bin = 0; m_wrap = 0; m_cv_valid = 0; m_cv_gray = 0;
    endtask

    initial begin
        logic [W-1:0] cv_seq [4];
        logic [W-1:0] cv_exp [4];
        cv_seq[0] = 8'h7F; cv_seq[1] = 8'h55; cv_seq[2] = 8'hFF; cv_seq[3] = 8'hAA;
        cv_exp[0] = 8'h40; cv_exp[1] = 8'h7F; cv_exp[2] = 8'h80; cv_exp[3] = 8'hFF;

        // Reset state, with every control active so it must be ignored
        #1;
        model_reset();
        check_all("reset0");
        en = 1'b1; dir = 1'b1; load = 1'b1; load_bin = 8'hAB;
        cv_valid_in = 1'b1; cv_bin_in = 8'h12;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset_hold");
        #2 rst = 1'b0;

        // Up count: 256 steps from 0 through the wrap
        for (int i = 1; i <= 256; i++) begin
            step("up", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
            if (i == 5)   check("up.gray5",  32'(gray), 32'h07);
            if (i == 255) check("up.grayFF", 32'(gray), 32'h80);
            if (i == 256) begin
                check("up.wrapbin", 32'(bin),  32'h00);
                check("up.wrapflg", 32'(wrap), 32'h1);
            end
        end
        step("up_after", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);

        // Load beats enable
        step("load33", 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h00);
        check("load33.gray", 32'(gray), 32'h2A);
        step("loadFF", 1'b1, 1'b0, 1'b1, 8'hFF, 1'b0, 8'h00);
        check("loadFF.gray", 32'(gray), 32'h80);
        check("loadFF.wrap", 32'(wrap), 32'h0);
        step("load_upFF", 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 8'h00);

        // Down count through zero, then hold
        step("load00", 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00);
        step("down1", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("down1.gray", 32'(gray), 32'h80);
        check("down1.wrap", 32'(wrap), 32'h1);
        step("down2", 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        check("down2.gray", 32'(gray), 32'h81);
        repeat (3) step("hold", 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("hold.bin", 32'(bin), 32'hFE);
        step("dirflip", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("dirflip.bin", 32'(bin), 32'hFF);

        // Converter back-to-back, then idle
        for (int i = 0; i < 4; i++) begin
            step("cv", 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, cv_seq[i]);
            check("cv.const", 32'(cv_gray_out), 32'(cv_exp[i]));
        end
        step("cv_idle", 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h11);
        check("cv_idle.gray", 32'(cv_gray_out), 32'hFF);

        // Randomized concurrent traffic on both paths
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0),
                 W'($urandom), 1'($urandom), W'($urandom));
        end

        // Asynchronous reset mid-count at 0x5A
        step("pre5A", 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 8'h3C);
        en = 1'b1; dir = 1'b1; cv_valid_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_held");
        #2 rst = 1'b0;
        step("post_rst", 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        check("post_rst.bin",  32'(bin),  32'h01);
        check("post_rst.gray", 32'(gray), 32'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
